// File: rtl/miriscv_rvfi_tracker.sv
// rtl/miriscv_rvfi_tracker.sv - in-order RVFI record queue with late load merge and multi-lane retire
module miriscv_rvfi_tracker #(
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    input  logic                 alloc_valid_i,
    output logic                 alloc_ready_o,
    input  logic [31:0]          alloc_insn_i,
    input  logic [31:0]          alloc_pc_rdata_i,
    input  logic [31:0]          alloc_pc_wdata_i,
    input  logic [4:0]           alloc_rs1_addr_i,
    input  logic [4:0]           alloc_rs2_addr_i,
    input  logic [31:0]          alloc_rs1_rdata_i,
    input  logic [31:0]          alloc_rs2_rdata_i,
    input  logic [4:0]           alloc_rd_addr_i,
    input  logic [31:0]          alloc_rd_wdata_i,
    input  logic                 alloc_trap_i,
    input  logic                 alloc_is_load_i,
    input  logic [31:0]          alloc_mem_addr_i,
    input  logic [3:0]           alloc_mem_rmask_i,
    input  logic [3:0]           alloc_mem_wmask_i,
    input  logic [31:0]          alloc_mem_wdata_i,
    input  logic                 ld_valid_i,
    input  logic [31:0]          ld_mem_rdata_i,
    input  logic [31:0]          ld_rd_wdata_i,
    output logic                 err_o,
    output logic [NRET-1:0]      rvfi_valid_o,
    output logic [NRET*64-1:0]   order_o,
    output logic [NRET*32-1:0]   insn_o,
    output logic [NRET-1:0]      trap_o,
    output logic [NRET-1:0]      halt_o,
    output logic [NRET-1:0]      intr_o,
    output logic [NRET*2-1:0]    mode_o,
    output logic [NRET*2-1:0]    ixl_o,
    output logic [NRET*5-1:0]    rs1_addr_o,
    output logic [NRET*5-1:0]    rs2_addr_o,
    output logic [NRET*32-1:0]   rs1_rdata_o,
    output logic [NRET*32-1:0]   rs2_rdata_o,
    output logic [NRET*5-1:0]    rd_addr_o,
    output logic [NRET*32-1:0]   rd_wdata_o,
    output logic [NRET*32-1:0]   pc_rdata_o,
    output logic [NRET*32-1:0]   pc_wdata_o,
    output logic [NRET*32-1:0]   mem_addr_o,
    output logic [NRET*4-1:0]    mem_rmask_o,
    output logic [NRET*4-1:0]    mem_wmask_o,
    output logic [NRET*32-1:0]   mem_rdata_o,
    output logic [NRET*32-1:0]   mem_wdata_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NRET + 1);

    logic [31:0] q_insn      [DEPTH];
    logic [31:0] q_pc_rdata  [DEPTH];
    logic [31:0] q_pc_wdata  [DEPTH];
    logic [4:0]  q_rs1_addr  [DEPTH];
    logic [4:0]  q_rs2_addr  [DEPTH];
    logic [31:0] q_rs1_rdata [DEPTH];
    logic [31:0] q_rs2_rdata [DEPTH];
    logic [4:0]  q_rd_addr   [DEPTH];
    logic [31:0] q_rd_wdata  [DEPTH];
    logic [31:0] q_mem_addr  [DEPTH];
    logic [3:0]  q_mem_rmask [DEPTH];
    logic [3:0]  q_mem_wmask [DEPTH];
    logic [31:0] q_mem_rdata [DEPTH];
    logic [31:0] q_mem_wdata [DEPTH];
    logic        q_trap      [DEPTH];
    logic [DEPTH-1:0] q_done;

    logic [AW:0]   rd_ptr, wr_ptr, rd_next, wr_next, count;
    logic          full_q, full_next;
    logic [63:0]   order_cnt;
    logic          alloc_fire;
    logic [AW-1:0] wr_idx;
    logic [CW-1:0] ret_cnt;
    logic          blocked;
    logic [AW-1:0] head_idx [NRET];
    logic [NRET-1:0] lane_en;
    logic [AW-1:0] scan_idx [DEPTH];
    logic          ld_found;
    logic [AW-1:0] ld_idx;
    logic [4:0]    a_rd_addr;
    logic [31:0]   a_rd_wdata;

    assign alloc_ready_o = ~full_q;
    assign alloc_fire    = alloc_valid_i & ~full_q;
    assign wr_idx        = wr_ptr[AW-1:0];
    assign count         = wr_ptr - rd_ptr;
    assign halt_o        = '0;
    assign intr_o        = '0;

    // Traps never write rd or touch memory; x0 never reports a write value.
    assign a_rd_addr  = alloc_trap_i ? 5'd0 : alloc_rd_addr_i;
    assign a_rd_wdata = (alloc_trap_i || alloc_is_load_i || alloc_rd_addr_i == 5'd0)
                        ? 32'd0 : alloc_rd_wdata_i;

    for (genvar g = 0; g < NRET; g++) begin : g_lane
        assign head_idx[g] = rd_ptr[AW-1:0] + AW'(g);
        assign lane_en[g]  = (CW'(g) < ret_cnt);
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_scan
        assign scan_idx[g] = rd_ptr[AW-1:0] + AW'(g);
    end

    always_comb begin
        ret_cnt = '0;
        blocked = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            if (!blocked && ((AW+1)'(i) < count) && q_done[head_idx[i]])
                ret_cnt = ret_cnt + CW'(1);
            else
                blocked = 1'b1;
        end
    end

    // Only loads are ever not-done, so the first not-done entry from the head
    // is the oldest pending load; same-cycle allocations are not yet visible.
    always_comb begin
        ld_found = 1'b0;
        ld_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!ld_found && ((AW+1)'(i) < count) && !q_done[scan_idx[i]]) begin
                ld_found = 1'b1;
                ld_idx   = scan_idx[i];
            end
        end
    end

    assign wr_next   = wr_ptr + (AW+1)'(alloc_fire);
    assign rd_next   = rd_ptr + (AW+1)'(ret_cnt);
    assign full_next = (wr_next[AW-1:0] == rd_next[AW-1:0]) && (wr_next[AW] != rd_next[AW]);

    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            q_insn[wr_idx]      <= alloc_insn_i;
            q_pc_rdata[wr_idx]  <= alloc_pc_rdata_i;
            q_pc_wdata[wr_idx]  <= alloc_pc_wdata_i;
            q_rs1_addr[wr_idx]  <= alloc_rs1_addr_i;
            q_rs2_addr[wr_idx]  <= alloc_rs2_addr_i;
            q_rs1_rdata[wr_idx] <= alloc_rs1_rdata_i;
            q_rs2_rdata[wr_idx] <= alloc_rs2_rdata_i;
            q_rd_addr[wr_idx]   <= a_rd_addr;
            q_rd_wdata[wr_idx]  <= a_rd_wdata;
            q_mem_addr[wr_idx]  <= alloc_mem_addr_i;
            q_mem_rmask[wr_idx] <= alloc_trap_i ? 4'd0 : alloc_mem_rmask_i;
            q_mem_wmask[wr_idx] <= alloc_trap_i ? 4'd0 : alloc_mem_wmask_i;
            q_mem_rdata[wr_idx] <= 32'd0;
            q_mem_wdata[wr_idx] <= alloc_mem_wdata_i;
            q_trap[wr_idx]      <= alloc_trap_i;
        end
        if (ld_valid_i && ld_found) begin
            q_mem_rdata[ld_idx] <= ld_mem_rdata_i;
            q_rd_wdata[ld_idx]  <= (q_rd_addr[ld_idx] == 5'd0) ? 32'd0 : ld_rd_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            full_q       <= 1'b0;
            order_cnt    <= '0;
            err_o        <= 1'b0;
            q_done       <= '0;
            rvfi_valid_o <= '0;
            order_o      <= '0;
            insn_o       <= '0;
            trap_o       <= '0;
            mode_o       <= '0;
            ixl_o        <= '0;
            rs1_addr_o   <= '0;
            rs2_addr_o   <= '0;
            rs1_rdata_o  <= '0;
            rs2_rdata_o  <= '0;
            rd_addr_o    <= '0;
            rd_wdata_o   <= '0;
            pc_rdata_o   <= '0;
            pc_wdata_o   <= '0;
            mem_addr_o   <= '0;
            mem_rmask_o  <= '0;
            mem_wmask_o  <= '0;
            mem_rdata_o  <= '0;
            mem_wdata_o  <= '0;
        end else begin
            if (alloc_fire)
                q_done[wr_idx] <= !(alloc_is_load_i && !alloc_trap_i);
            if (ld_valid_i) begin
                if (ld_found)
                    q_done[ld_idx] <= 1'b1;
                else
                    err_o <= 1'b1;
            end
            wr_ptr    <= wr_next;
            rd_ptr    <= rd_next;
            full_q    <= full_next;
            order_cnt <= order_cnt + 64'(ret_cnt);
            for (int i = 0; i < NRET; i++) begin
                rvfi_valid_o[i]        <= lane_en[i];
                order_o[i*64 +: 64]    <= lane_en[i] ? order_cnt + 64'(i) : 64'd0;
                insn_o[i*32 +: 32]     <= lane_en[i] ? q_insn[head_idx[i]] : 32'd0;
                trap_o[i]              <= lane_en[i] ? q_trap[head_idx[i]] : 1'b0;
                mode_o[i*2 +: 2]       <= lane_en[i] ? 2'b11 : 2'b00;
                ixl_o[i*2 +: 2]        <= lane_en[i] ? 2'b01 : 2'b00;
                rs1_addr_o[i*5 +: 5]   <= lane_en[i] ? q_rs1_addr[head_idx[i]] : 5'd0;
                rs2_addr_o[i*5 +: 5]   <= lane_en[i] ? q_rs2_addr[head_idx[i]] : 5'd0;
                rs1_rdata_o[i*32 +: 32] <= lane_en[i] ? q_rs1_rdata[head_idx[i]] : 32'd0;
                rs2_rdata_o[i*32 +: 32] <= lane_en[i] ? q_rs2_rdata[head_idx[i]] : 32'd0;
                rd_addr_o[i*5 +: 5]    <= lane_en[i] ? q_rd_addr[head_idx[i]] : 5'd0;
                rd_wdata_o[i*32 +: 32] <= lane_en[i] ? q_rd_wdata[head_idx[i]] : 32'd0;
                pc_rdata_o[i*32 +: 32] <= lane_en[i] ? q_pc_rdata[head_idx[i]] : 32'd0;
                pc_wdata_o[i*32 +: 32] <= lane_en[i] ? q_pc_wdata[head_idx[i]] : 32'd0;
                mem_addr_o[i*32 +: 32] <= lane_en[i] ? q_mem_addr[head_idx[i]] : 32'd0;
                mem_rmask_o[i*4 +: 4]  <= lane_en[i] ? q_mem_rmask[head_idx[i]] : 4'd0;
                mem_wmask_o[i*4 +: 4]  <= lane_en[i] ? q_mem_wmask[head_idx[i]] : 4'd0;
                mem_rdata_o[i*32 +: 32] <= lane_en[i] ? q_mem_rdata[head_idx[i]] : 32'd0;
                mem_wdata_o[i*32 +: 32] <= lane_en[i] ? q_mem_wdata[head_idx[i]] : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_miriscv_rvfi_tracker.sv
// tb/tb_miriscv_rvfi_tracker.sv - directed bench for miriscv_rvfi_tracker (NRET=2, DEPTH=8)
module tb_miriscv_rvfi_tracker;
    localparam int NRET  = 2;
    localparam int DEPTH = 8;

    logic clk_i = 1'b0;
    logic arstn_i = 1'b0;
    logic alloc_valid_i, alloc_ready_o;
    logic [31:0] alloc_insn_i, alloc_pc_rdata_i, alloc_pc_wdata_i;
    logic [4:0]  alloc_rs1_addr_i, alloc_rs2_addr_i, alloc_rd_addr_i;
    logic [31:0] alloc_rs1_rdata_i, alloc_rs2_rdata_i, alloc_rd_wdata_i;
    logic        alloc_trap_i, alloc_is_load_i;
    logic [31:0] alloc_mem_addr_i, alloc_mem_wdata_i;
    logic [3:0]  alloc_mem_rmask_i, alloc_mem_wmask_i;
    logic        ld_valid_i;
    logic [31:0] ld_mem_rdata_i, ld_rd_wdata_i;
    logic        err_o;
    logic [NRET-1:0]    rvfi_valid_o, trap_o, halt_o, intr_o;
    logic [NRET*64-1:0] order_o;
    logic [NRET*32-1:0] insn_o, rs1_rdata_o, rs2_rdata_o, rd_wdata_o, pc_rdata_o, pc_wdata_o;
    logic [NRET*32-1:0] mem_addr_o, mem_rdata_o, mem_wdata_o;
    logic [NRET*2-1:0]  mode_o, ixl_o;
    logic [NRET*5-1:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [NRET*4-1:0]  mem_rmask_o, mem_wmask_o;

    int n_tests = 0;
    int n_fail  = 0;

    miriscv_rvfi_tracker #(.NRET(NRET), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_insn_i(alloc_insn_i), .alloc_pc_rdata_i(alloc_pc_rdata_i),
        .alloc_pc_wdata_i(alloc_pc_wdata_i),
        .alloc_rs1_addr_i(alloc_rs1_addr_i), .alloc_rs2_addr_i(alloc_rs2_addr_i),
        .alloc_rs1_rdata_i(alloc_rs1_rdata_i), .alloc_rs2_rdata_i(alloc_rs2_rdata_i),
        .alloc_rd_addr_i(alloc_rd_addr_i), .alloc_rd_wdata_i(alloc_rd_wdata_i),
        .alloc_trap_i(alloc_trap_i), .alloc_is_load_i(alloc_is_load_i),
        .alloc_mem_addr_i(alloc_mem_addr_i), .alloc_mem_rmask_i(alloc_mem_rmask_i),
        .alloc_mem_wmask_i(alloc_mem_wmask_i), .alloc_mem_wdata_i(alloc_mem_wdata_i),
        .ld_valid_i(ld_valid_i), .ld_mem_rdata_i(ld_mem_rdata_i), .ld_rd_wdata_i(ld_rd_wdata_i),
        .err_o(err_o), .rvfi_valid_o(rvfi_valid_o), .order_o(order_o), .insn_o(insn_o),
        .trap_o(trap_o), .halt_o(halt_o), .intr_o(intr_o), .mode_o(mode_o), .ixl_o(ixl_o),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_rdata_o(rs1_rdata_o), .rs2_rdata_o(rs2_rdata_o),
        .rd_addr_o(rd_addr_o), .rd_wdata_o(rd_wdata_o),
        .pc_rdata_o(pc_rdata_o), .pc_wdata_o(pc_wdata_o), .mem_addr_o(mem_addr_o),
        .mem_rmask_o(mem_rmask_o), .mem_wmask_o(mem_wmask_o),
        .mem_rdata_o(mem_rdata_o), .mem_wdata_o(mem_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        alloc_valid_i = 1'b0; alloc_insn_i = '0; alloc_pc_rdata_i = '0; alloc_pc_wdata_i = '0;
        alloc_rs1_addr_i = '0; alloc_rs2_addr_i = '0; alloc_rs1_rdata_i = '0; alloc_rs2_rdata_i = '0;
        alloc_rd_addr_i = '0; alloc_rd_wdata_i = '0; alloc_trap_i = 1'b0; alloc_is_load_i = 1'b0;
        alloc_mem_addr_i = '0; alloc_mem_rmask_i = '0; alloc_mem_wmask_i = '0; alloc_mem_wdata_i = '0;
    endtask

    task automatic put(input logic [31:0] pc, input logic is_load, input logic trap,
                       input logic [4:0] rd, input logic [31:0] rd_wdata);
        alloc_valid_i     = 1'b1;
        alloc_insn_i      = 32'h0000_0013 | (pc << 8);
        alloc_pc_rdata_i  = pc;
        alloc_pc_wdata_i  = pc + 32'd4;
        alloc_rs1_addr_i  = 5'd1;
        alloc_rs1_rdata_i = 32'h1000_0000 + pc;
        alloc_rd_addr_i   = rd;
        alloc_rd_wdata_i  = rd_wdata;
        alloc_is_load_i   = is_load;
        alloc_trap_i      = trap;
        alloc_mem_addr_i  = is_load ? 32'h2000_0000 + pc : 32'd0;
        alloc_mem_rmask_i = is_load ? 4'hf : 4'h0;
    endtask

    task automatic do_reset();
        idle();
        ld_valid_i = 1'b0; ld_mem_rdata_i = '0; ld_rd_wdata_i = '0;
        arstn_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 arstn_i = 1'b1;
    endtask

    initial begin
        // reset state and three back-to-back ALU ops
        do_reset();
        check("rst_valid", 64'(rvfi_valid_o), 64'd0);
        check("rst_ready", 64'(alloc_ready_o), 64'd1);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_order", order_o[63:0], 64'd0);
        put(32'h80, 0, 0, 5'd3, 32'h33); step();
        check("t1_empty", 64'(rvfi_valid_o), 64'd0);
        put(32'h84, 0, 0, 5'd3, 32'h34); step();
        check("t1_v0", 64'(rvfi_valid_o), 64'b01);
        check("t1_pc0", 64'(pc_rdata_o[31:0]), 64'h80);
        check("t1_ord0", order_o[63:0], 64'd0);
        check("t1_mode", 64'(mode_o[1:0]), 64'd3);
        check("t1_ixl", 64'(ixl_o[1:0]), 64'd1);
        check("t1_rdw0", 64'(rd_wdata_o[31:0]), 64'h33);
        put(32'h88, 0, 0, 5'd3, 32'h35); step();
        check("t1_v1", 64'(rvfi_valid_o), 64'b01);
        check("t1_pc1", 64'(pc_rdata_o[31:0]), 64'h84);
        check("t1_ord1", order_o[63:0], 64'd1);
        idle(); step();
        check("t1_v2", 64'(rvfi_valid_o), 64'b01);
        check("t1_pc2", 64'(pc_rdata_o[31:0]), 64'h88);
        check("t1_ord2", order_o[63:0], 64'd2);
        step();
        check("t1_quiet", 64'(rvfi_valid_o), 64'd0);
        check("t1_mode_idle", 64'(mode_o), 64'd0);

        // load blocks two younger ALU ops, then dual retire
        do_reset();
        put(32'h100, 1, 0, 5'd5, 32'hFFFF); step();
        check("t2_wait_e1", 64'(rvfi_valid_o), 64'd0);
        put(32'h104, 0, 0, 5'd6, 32'h66); step();
        check("t2_wait_e2", 64'(rvfi_valid_o), 64'd0);
        put(32'h108, 0, 0, 5'd7, 32'h77); step();
        idle();
        for (int c = 0; c < 3; c++) begin
            check("t2_wait", 64'(rvfi_valid_o), 64'd0);
            step();
        end
        ld_valid_i = 1'b1; ld_mem_rdata_i = 32'hDEADBEEF; ld_rd_wdata_i = 32'hDEADBEEF;
        step();
        ld_valid_i = 1'b0;
        check("t2_done_not_yet", 64'(rvfi_valid_o), 64'd0);
        step();
        check("t2_dual_v", 64'(rvfi_valid_o), 64'b11);
        check("t2_l0_pc", 64'(pc_rdata_o[31:0]), 64'h100);
        check("t2_l0_ord", order_o[63:0], 64'd0);
        check("t2_l0_rdw", 64'(rd_wdata_o[31:0]), 64'hDEADBEEF);
        check("t2_l0_mrd", 64'(mem_rdata_o[31:0]), 64'hDEADBEEF);
        check("t2_l0_rd", 64'(rd_addr_o[4:0]), 64'd5);
        check("t2_l1_pc", 64'(pc_rdata_o[63:32]), 64'h104);
        check("t2_l1_ord", order_o[127:64], 64'd1);
        check("t2_l1_rdw", 64'(rd_wdata_o[63:32]), 64'h66);
        check("t2_l1_mode", 64'(mode_o[3:2]), 64'd3);
        step();
        check("t2_last_v", 64'(rvfi_valid_o), 64'b01);
        check("t2_last_pc", 64'(pc_rdata_o[31:0]), 64'h108);
        check("t2_last_ord", order_o[63:0], 64'd2);
        check("t2_l1_zero", order_o[127:64], 64'd0);
        check("t2_err", 64'(err_o), 64'd0);

        // fill the queue with pending loads
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            put(32'h200 + 32'(i * 4), 1, 0, 5'd1, 32'd0); step();
            if (i == DEPTH - 2) check("t3_ready_7", 64'(alloc_ready_o), 64'd1);
        end
        idle();
        check("t3_full", 64'(alloc_ready_o), 64'd0);
        ld_valid_i = 1'b1; ld_mem_rdata_i = 32'h55; ld_rd_wdata_i = 32'h55;
        step();
        ld_valid_i = 1'b0;
        check("t3_still_full", 64'(alloc_ready_o), 64'd0);
        check("t3_no_ret", 64'(rvfi_valid_o), 64'd0);
        step();
        check("t3_ret_v", 64'(rvfi_valid_o), 64'b01);
        check("t3_ret_pc", 64'(pc_rdata_o[31:0]), 64'h200);
        check("t3_ret_rdw", 64'(rd_wdata_o[31:0]), 64'h55);
        check("t3_ready", 64'(alloc_ready_o), 64'd1);

        // trapping load retires immediately; stray response flags err
        do_reset();
        put(32'h300, 1, 1, 5'd7, 32'h99); step();
        idle(); step();
        check("t4_v", 64'(rvfi_valid_o), 64'b01);
        check("t4_trap", 64'(trap_o[0]), 64'd1);
        check("t4_rd", 64'(rd_addr_o[4:0]), 64'd0);
        check("t4_rdw", 64'(rd_wdata_o[31:0]), 64'd0);
        check("t4_rmask", 64'(mem_rmask_o[3:0]), 64'd0);
        check("t4_err0", 64'(err_o), 64'd0);
        ld_valid_i = 1'b1; ld_rd_wdata_i = 32'h77;
        step();
        ld_valid_i = 1'b0;
        check("t4_err1", 64'(err_o), 64'd1);
        check("t4_quiet", 64'(rvfi_valid_o), 64'd0);
        step();
        check("t4_err_sticky", 64'(err_o), 64'd1);

        // x0 destination and order wrap
        do_reset();
        put(32'h400, 0, 0, 5'd0, 32'h1234); step();
        idle(); step();
        check("t5_v", 64'(rvfi_valid_o), 64'b01);
        check("t5_rdw", 64'(rd_wdata_o[31:0]), 64'd0);
        force dut.order_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        #2 release dut.order_cnt;
        @(posedge clk_i); #1;
        put(32'h404, 0, 0, 5'd2, 32'h1); step();
        put(32'h408, 0, 0, 5'd2, 32'h2); step();
        check("t5_max_pc", 64'(pc_rdata_o[31:0]), 64'h404);
        check("t5_max_ord", order_o[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        idle(); step();
        check("t5_wrap_pc", 64'(pc_rdata_o[31:0]), 64'h408);
        check("t5_wrap_ord", order_o[63:0], 64'd0);

        // asynchronous reset with records queued
        do_reset();
        ld_valid_i = 1'b1;
        put(32'h500, 0, 0, 5'd4, 32'h44); step();
        ld_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(32'h504 + 32'(i * 4), 1, 0, 5'd4, 32'd0); step();
            if (i == 0) check("t6_pre_v", 64'(rvfi_valid_o), 64'b01);
        end
        idle();
        check("t6_pre_err", 64'(err_o), 64'd1);
        #2 arstn_i = 1'b0;
        #1;
        check("t6_rst_v", 64'(rvfi_valid_o), 64'd0);
        check("t6_rst_err", 64'(err_o), 64'd0);
        check("t6_rst_ready", 64'(alloc_ready_o), 64'd1);
        check("t6_rst_pc", 64'(pc_rdata_o), 64'd0);
        @(posedge clk_i);
        #1 arstn_i = 1'b1;
        ld_valid_i = 1'b1; ld_rd_wdata_i = 32'hABCD;
        step();
        ld_valid_i = 1'b0;
        check("t6_discard_err", 64'(err_o), 64'd1);
        check("t6_discard_v", 64'(rvfi_valid_o), 64'd0);
        put(32'h600, 0, 0, 5'd8, 32'h88); step();
        idle(); step();
        check("t6_new_v", 64'(rvfi_valid_o), 64'b01);
        check("t6_new_pc", 64'(pc_rdata_o[31:0]), 64'h600);
        check("t6_new_ord", order_o[63:0], 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
